mem_stage: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/mem_stage_llsc_link.sv | 40 ++++
 rtl/mem_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word width, memory-stage FSM encoding and write-back select codes.
package cpu_types_pkg;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [4:0]        regsel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        HALTED = 2'b10
    } memstate_t;

    // 2'b11 is not named: it falls back to the ALU result.
    localparam logic [1:0] RFIN_ALU  = 2'b00;
    localparam logic [1:0] RFIN_LOAD = 2'b01;
    localparam logic [1:0] RFIN_NPC  = 2'b10;

    function automatic word_t sc_result(input logic success);
        return {{(WORD_W-1){1'b0}}, success};
    endfunction

endpackage

// File: rtl/mem_stage_llsc_link.sv
// LL/SC link register for the memory stage; only present when MEM_LLSC_EN is defined.
`ifdef MEM_LLSC_EN
module llsc_link
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  set_en,
    input  addr_t set_addr,
    input  logic  wr_done,
    input  addr_t wr_addr,
    input  addr_t chk_addr,
    output logic  link_valid,
    output addr_t link_addr,
    output logic  link_match
);

    logic  valid_q;
    addr_t addr_q;

    // A completed LL (re)arms the link; any completed store to the linked
    // address breaks it, which also covers a successful SC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else if (set_en) begin
            valid_q <= 1'b1;
            addr_q  <= set_addr;
        end else if (wr_done && valid_q && (wr_addr == addr_q)) begin
            valid_q <= 1'b0;
        end
    end

    assign link_valid = valid_q;
    assign link_addr  = addr_q;
    assign link_match = valid_q && (chk_addr == addr_q);

endmodule
`endif

// File: rtl/mem_stage.sv
// MIPS memory stage: data-memory request/wait FSM, write-back select and MEM/WB register.
// Optional LL/SC link support is built when MEM_LLSC_EN is defined.
module mem_stage
    import cpu_types_pkg::*;
(
    input  logic      CLK,
    input  logic      nRST,
    input  word_t     exmem_instr,
    input  word_t     exmem_npc,
    input  word_t     exmem_aluout,
    input  word_t     exmem_rdat2,
    input  logic [1:0] exmem_rfInSel,
    input  regsel_t   exmem_wsel,
    input  logic      exmem_rfWEN,
    input  logic      exmem_dREN,
    input  logic      exmem_dWEN,
    input  logic      exmem_halt,
    input  logic      exmem_ll,
    input  logic      exmem_sc,
    output logic      dmemREN,
    output logic      dmemWEN,
    output word_t     dmemaddr,
    output word_t     dmemstore,
    input  word_t     dmemload,
    input  logic      dhit,
    output logic      stall_o,
    output word_t     wb_instr,
    output word_t     wb_npc,
    output word_t     wb_wdat,
    output regsel_t   wb_wsel,
    output logic      wb_rfWEN,
    output logic      wb_halt,
    output logic      halt_o,
    output memstate_t dbg_state
);

    // Handshake: a request (dmemREN or dmemWEN) is held stable with the same
    // address/data until the cycle dhit is high; that cycle completes it, the
    // EX/MEM register advances on the same edge, and dhit without a request
    // is ignored.

    memstate_t state_q, state_d;
    logic      running;
    logic      rd_req, wr_req, mem_req, stall_i;
    logic      sc_blocked;
    word_t     wdat_d;
    logic      wb_rfwen_d, wb_halt_d;

    assign running = (state_q != HALTED);

`ifdef MEM_LLSC_EN
    logic  link_valid, link_match;
    addr_t link_addr;
    logic  unused_link;

    llsc_link u_link (
        .clk        (CLK),
        .rst_n      (nRST),
        .set_en     (exmem_ll && rd_req && dhit),
        .set_addr   (exmem_aluout),
        .wr_done    (wr_req && dhit),
        .wr_addr    (exmem_aluout),
        .chk_addr   (exmem_aluout),
        .link_valid (link_valid),
        .link_addr  (link_addr),
        .link_match (link_match)
    );

    assign unused_link = ^{link_valid, link_addr};
    // A failing SC never reaches memory and retires as a plain ALU-style op.
    assign sc_blocked  = exmem_sc && !link_match;
    assign rd_req      = running && (exmem_dREN || exmem_ll);
`else
    logic unused_llsc;

    assign unused_llsc = exmem_ll;
    assign sc_blocked  = 1'b0;
    assign rd_req      = running && exmem_dREN;
`endif

    assign wr_req  = running && exmem_dWEN && !sc_blocked;
    assign mem_req = rd_req || wr_req;
    assign stall_i = mem_req && !dhit;

    // Request outputs follow EX/MEM combinationally but are held low in reset.
    assign dmemREN   = nRST && rd_req;
    assign dmemWEN   = nRST && wr_req;
    assign dmemaddr  = exmem_aluout;
    assign dmemstore = exmem_rdat2;
    assign stall_o   = nRST && stall_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_req && !dhit) begin
                    state_d = WAIT;
                end else if (!mem_req && exmem_halt) begin
                    state_d = HALTED;
                end
            end
            WAIT: begin
                if (dhit || !mem_req) begin
                    state_d = IDLE;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wdat_d = exmem_aluout;
        case (exmem_rfInSel)
            RFIN_LOAD: wdat_d = dmemload;
            RFIN_NPC:  wdat_d = exmem_npc;
            default:   wdat_d = exmem_aluout;
        endcase
`ifdef MEM_LLSC_EN
        if (exmem_sc) begin
            wdat_d = sc_result(wr_req);
        end
`endif
    end

    always_comb begin
        wb_rfwen_d = exmem_rfWEN && running;
`ifndef MEM_LLSC_EN
        // Without link support SC is an ordinary store and writes no register.
        if (exmem_sc) begin
            wb_rfwen_d = 1'b0;
        end
`endif
        wb_halt_d = exmem_halt || !running;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            wb_instr <= '0;
            wb_npc   <= '0;
            wb_wdat  <= '0;
            wb_wsel  <= '0;
            wb_rfWEN <= 1'b0;
            wb_halt  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (stall_i) begin
                wb_instr <= '0;
                wb_npc   <= '0;
                wb_wdat  <= '0;
                wb_wsel  <= '0;
                wb_rfWEN <= 1'b0;
                wb_halt  <= 1'b0;
            end else begin
                wb_instr <= exmem_instr;
                wb_npc   <= exmem_npc;
                wb_wdat  <= wdat_d;
                wb_wsel  <= exmem_wsel;
                wb_rfWEN <= wb_rfwen_d;
                wb_halt  <= wb_halt_d;
            end
        end
    end

    assign halt_o    = (state_q == HALTED);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (default build and MEM_LLSC_EN build).
module tb_mem_stage;
    import cpu_types_pkg::*;

    logic       CLK, nRST;
    word_t      exmem_instr, exmem_npc, exmem_aluout, exmem_rdat2;
    logic [1:0] exmem_rfInSel;
    regsel_t    exmem_wsel;
    logic       exmem_rfWEN, exmem_dREN, exmem_dWEN, exmem_halt, exmem_ll, exmem_sc;
    logic       dmemREN, dmemWEN;
    word_t      dmemaddr, dmemstore, dmemload;
    logic       dhit, stall_o;
    word_t      wb_instr, wb_npc, wb_wdat;
    regsel_t    wb_wsel;
    logic       wb_rfWEN, wb_halt, halt_o;
    memstate_t  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int stall_cycles;
    logic [31:0] exp_q[$];

    mem_stage dut (
        .CLK(CLK), .nRST(nRST),
        .exmem_instr(exmem_instr), .exmem_npc(exmem_npc),
        .exmem_aluout(exmem_aluout), .exmem_rdat2(exmem_rdat2),
        .exmem_rfInSel(exmem_rfInSel), .exmem_wsel(exmem_wsel),
        .exmem_rfWEN(exmem_rfWEN), .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
        .exmem_halt(exmem_halt), .exmem_ll(exmem_ll), .exmem_sc(exmem_sc),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dmemload(dmemload), .dhit(dhit), .stall_o(stall_o),
        .wb_instr(wb_instr), .wb_npc(wb_npc), .wb_wdat(wb_wdat), .wb_wsel(wb_wsel),
        .wb_rfWEN(wb_rfWEN), .wb_halt(wb_halt), .halt_o(halt_o), .dbg_state(dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_exmem();
        exmem_instr = '0; exmem_npc = '0; exmem_aluout = '0; exmem_rdat2 = '0;
        exmem_rfInSel = RFIN_ALU; exmem_wsel = '0; exmem_rfWEN = 0;
        exmem_dREN = 0; exmem_dWEN = 0; exmem_halt = 0; exmem_ll = 0; exmem_sc = 0;
        dhit = 0; dmemload = '0;
    endtask

    task automatic check_wb_zero(input string tag);
        check_eq({tag, ".instr"}, wb_instr, 32'h0);
        check_eq({tag, ".npc"},   wb_npc,   32'h0);
        check_eq({tag, ".wdat"},  wb_wdat,  32'h0);
        check_eq({tag, ".wsel"},  32'(wb_wsel),  32'h0);
        check_eq({tag, ".rfwen"}, 32'(wb_rfWEN), 32'h0);
        check_eq({tag, ".halt"},  32'(wb_halt),  32'h0);
    endtask

    task automatic check_wdat(input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        check_eq(tag, wb_wdat, e);
    endtask

    // driver + checks
    initial begin
        clear_exmem();
        nRST = 1'b0;
        exmem_dREN = 1'b1;
        exmem_aluout = 32'h0000_0020;
        #2;
        check_eq("rst.dren", 32'(dmemREN), 32'h0);
        check_eq("rst.stall", 32'(stall_o), 32'h0);
        check_eq("rst.halt", 32'(halt_o), 32'h0);
        check_eq("rst.state", 32'(dbg_state), 32'(IDLE));
        check_wb_zero("rst.wb");
        repeat (2) tick();
        check_eq("rst2.dren", 32'(dmemREN), 32'h0);
        check_wb_zero("rst2.wb");

        // release: the held load issues, misses, then hits
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        check_eq("rel.dren", 32'(dmemREN), 32'h1);
        check_eq("rel.addr", dmemaddr, 32'h20);
        check_eq("rel.stall", 32'(stall_o), 32'h1);
        check_eq("rel.state", 32'(dbg_state), 32'(WAIT));
        exmem_rfInSel = RFIN_LOAD; exmem_rfWEN = 1; exmem_wsel = 5'd3;
        dhit = 1; dmemload = 32'h0000_1234;
        #1;
        check_eq("rel.hitstall", 32'(stall_o), 32'h0);
        exp_q.push_back(32'h0000_1234);
        tick();
        check_wdat("rel.wdat");
        check_eq("rel.state2", 32'(dbg_state), 32'(IDLE));

        // ADD
        clear_exmem();
        exmem_instr = 32'h0022_2820; exmem_npc = 32'h104; exmem_aluout = 32'h10;
        exmem_wsel = 5'd5; exmem_rfWEN = 1; exmem_rfInSel = RFIN_ALU;
        #1;
        check_eq("add.stall", 32'(stall_o), 32'h0);
        check_eq("add.dren", 32'(dmemREN), 32'h0);
        check_eq("add.dwen", 32'(dmemWEN), 32'h0);
        exp_q.push_back(32'h10);
        tick();
        check_wdat("add.wdat");
        check_eq("add.wsel", 32'(wb_wsel), 32'd5);
        check_eq("add.rfwen", 32'(wb_rfWEN), 32'h1);
        check_eq("add.instr", wb_instr, 32'h0022_2820);
        check_eq("add.npc", wb_npc, 32'h104);

        // JAL selects npc; select 11 falls back to ALU
        exmem_rfInSel = RFIN_NPC; exmem_npc = 32'h200; exmem_aluout = 32'h999; exmem_wsel = 5'd31;
        exp_q.push_back(32'h200);
        tick();
        check_wdat("jal.wdat");
        check_eq("jal.wsel", 32'(wb_wsel), 32'd31);
        exmem_rfInSel = 2'b11;
        exp_q.push_back(32'h999);
        tick();
        check_wdat("sel3.wdat");

        // LW, dhit 3 cycles after the request
        clear_exmem();
        exmem_instr = 32'h8C08_0080; exmem_npc = 32'h110; exmem_aluout = 32'h80;
        exmem_dREN = 1; exmem_rfInSel = RFIN_LOAD; exmem_wsel = 5'd8; exmem_rfWEN = 1;
        #1;
        check_eq("lw.dren", 32'(dmemREN), 32'h1);
        check_eq("lw.addr", dmemaddr, 32'h80);
        stall_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (stall_o) stall_cycles++;
            tick();
            check_wb_zero("lw.bubble");
            check_eq("lw.state", 32'(dbg_state), 32'(WAIT));
        end
        dhit = 1; dmemload = 32'hDEAD_BEEF;
        #1;
        check_eq("lw.stallcnt", 32'(stall_cycles), 32'd3);
        check_eq("lw.hitstall", 32'(stall_o), 32'h0);
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        check_wdat("lw.wdat");
        check_eq("lw.wsel", 32'(wb_wsel), 32'd8);
        check_eq("lw.rfwen", 32'(wb_rfWEN), 32'h1);
        check_eq("lw.state2", 32'(dbg_state), 32'(IDLE));

        // SW with same-cycle hit
        clear_exmem();
        exmem_dWEN = 1; exmem_aluout = 32'h44; exmem_rdat2 = 32'hCAFE_F00D; dhit = 1;
        #1;
        check_eq("sw.dwen", 32'(dmemWEN), 32'h1);
        check_eq("sw.dren", 32'(dmemREN), 32'h0);
        check_eq("sw.addr", dmemaddr, 32'h44);
        check_eq("sw.store", dmemstore, 32'hCAFE_F00D);
        check_eq("sw.stall", 32'(stall_o), 32'h0);
        tick();
        check_eq("sw.state", 32'(dbg_state), 32'(IDLE));

        // stray dhit without a request
        clear_exmem();
        dhit = 1;
        #1;
        check_eq("stray.stall", 32'(stall_o), 32'h0);
        tick();
        check_eq("stray.state", 32'(dbg_state), 32'(IDLE));

`ifndef MEM_LLSC_EN
        // SC acts as SW and never writes the register file
        clear_exmem();
        exmem_sc = 1; exmem_dWEN = 1; exmem_rfWEN = 1; exmem_aluout = 32'h40; dhit = 1;
        #1;
        check_eq("sc.dwen", 32'(dmemWEN), 32'h1);
        tick();
        check_eq("sc.rfwen", 32'(wb_rfWEN), 32'h0);
`else
        // LL 0x40 hit, then SC 0x40 succeeds
        clear_exmem();
        exmem_ll = 1; exmem_dREN = 1; exmem_rfInSel = RFIN_LOAD; exmem_rfWEN = 1;
        exmem_aluout = 32'h40; dhit = 1; dmemload = 32'h77;
        exp_q.push_back(32'h77);
        tick();
        check_wdat("ll.wdat");
        clear_exmem();
        exmem_sc = 1; exmem_dWEN = 1; exmem_rfWEN = 1; exmem_aluout = 32'h40;
        exmem_rdat2 = 32'h5; dhit = 1;
        #1;
        check_eq("sc1.dwen", 32'(dmemWEN), 32'h1);
        exp_q.push_back(32'h1);
        tick();
        check_wdat("sc1.wdat");
        // link consumed: a second SC fails with no request
        dhit = 0;
        #1;
        check_eq("sc2.dwen", 32'(dmemWEN), 32'h0);
        check_eq("sc2.stall", 32'(stall_o), 32'h0);
        exp_q.push_back(32'h0);
        tick();
        check_wdat("sc2.wdat");
        // LL, SW to the link address, SC fails
        clear_exmem();
        exmem_ll = 1; exmem_dREN = 1; exmem_rfInSel = RFIN_LOAD; exmem_rfWEN = 1;
        exmem_aluout = 32'h40; dhit = 1; dmemload = 32'h88;
        tick();
        clear_exmem();
        exmem_dWEN = 1; exmem_aluout = 32'h40; exmem_rdat2 = 32'h9; dhit = 1;
        tick();
        clear_exmem();
        exmem_sc = 1; exmem_dWEN = 1; exmem_rfWEN = 1; exmem_aluout = 32'h40;
        #1;
        check_eq("sc3.dwen", 32'(dmemWEN), 32'h0);
        check_eq("sc3.stall", 32'(stall_o), 32'h0);
        exmem_rfInSel = RFIN_ALU;
        exp_q.push_back(32'h0);
        tick();
        check_wdat("sc3.wdat");
`endif

        // reset during a wait
        clear_exmem();
        exmem_dREN = 1; exmem_aluout = 32'h60; exmem_rfWEN = 1;
        tick();
        check_eq("mid.state", 32'(dbg_state), 32'(WAIT));
        nRST = 1'b0;
        #1;
        check_eq("mid.dren", 32'(dmemREN), 32'h0);
        check_eq("mid.stall", 32'(stall_o), 32'h0);
        check_eq("mid.rststate", 32'(dbg_state), 32'(IDLE));
        clear_exmem();
        dhit = 1;
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        check_eq("mid.after", 32'(dbg_state), 32'(IDLE));
        check_eq("mid.rfwen", 32'(wb_rfWEN), 32'h0);

        // HALT, then a load held in EX/MEM
        clear_exmem();
        exmem_halt = 1;
        tick();
        check_eq("halt.wbhalt", 32'(wb_halt), 32'h1);
        check_eq("halt.halt", 32'(halt_o), 32'h1);
        check_eq("halt.state", 32'(dbg_state), 32'(HALTED));
        exmem_halt = 0; exmem_dREN = 1; exmem_rfWEN = 1; exmem_rfInSel = RFIN_LOAD;
        exmem_aluout = 32'h90;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("halted.dren", 32'(dmemREN), 32'h0);
            check_eq("halted.stall", 32'(stall_o), 32'h0);
            tick();
            check_eq("halted.halt", 32'(halt_o), 32'h1);
            check_eq("halted.wbhalt", 32'(wb_halt), 32'h1);
            check_eq("halted.rfwen", 32'(wb_rfWEN), 32'h0);
        end

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
